weight_pingpong_buf: RTL
========================

Name: weight_pingpong_buf

Overview:
- Double-buffered (ping-pong) weight store directly downstream of the flash data loader.
- Fill side: consumes the loader's 256-bit words (write strobe + data) and its per-layer finish pulse, and issues the loader's per-layer start pulse whenever a bank is free.
- Read side: exposes one full bank at a time to the compute engine through a registered read port, so flash loading of layer N+1 overlaps computation of layer N.

Parameters:
- DATA_W, 256, word width; equals the loader output width.
- DEPTH, 64, words per bank.
- ADDR_W, 6, read/write address width; DEPTH = 2**ADDR_W.

Ports:
- sys_clk  input  1  system clock; all logic on the rising edge.
- sys_rst  input  1  synchronous, active-high reset.
- fill_en  input  1  level; 1 = more layers remain to load.
- layer_load_start  output  1  one-cycle pulse requesting the loader to fetch the next layer.
- in_en  input  1  loader word strobe.
- in_data  input  DATA_W  loader word.
- in_finish  input  1  loader layer-finish pulse.
- buf_ready  output  1  read bank is FULL and readable.
- rd_en  input  1  read request.
- rd_addr  input  ADDR_W  read word address.
- rd_data  output  DATA_W  registered read data.
- rd_valid  output  1  rd_data valid, one cycle after an accepted rd_en.
- rd_words  output  ADDR_W+1  word count of the current read bank.
- compute_done  input  1  pulse; releases the read bank.
- err  output  1  sticky protocol error flag.

Behaviour:
- Storage: two banks of DEPTH x DATA_W; per-bank state EMPTY/FILLING/FULL; per-bank count cnt[b] of width ADDR_W+1.
- Pointers: wbank (fill bank) and rbank (read bank), 1 bit each.
- Reset values: all banks EMPTY; wbank=rbank=0; waddr=0; cnt=0; all outputs 0.
- Fill FSM, IDLE:
  - if fill_en=1 and state[wbank]=EMPTY: pulse layer_load_start for exactly 1 cycle, set state[wbank]=FILLING, waddr=0, go to FILL.
- Fill FSM, FILL:
  - in_en=1 and waddr<DEPTH: write in_data to mem[wbank][waddr]; waddr++.
  - in_en=1 and waddr=DEPTH: word dropped; err set.
  - in_finish=1: cnt[wbank]=waddr including any same-cycle write; state[wbank]=FULL; wbank toggles; go to IDLE.
  - in_finish with zero words: legal; bank becomes FULL with cnt=0.
- in_en or in_finish while in IDLE: ignored; err set.
- Loader restart: the next layer_load_start occurs no earlier than 1 cycle after IDLE is re-entered; a bank freed by compute_done is seen by IDLE the cycle after release.
- Read side:
  - buf_ready = (state[rbank]==FULL); rd_words = cnt[rbank] (0 when not ready).
  - rd_en accepted only when buf_ready=1 → rd_valid=1 next cycle, rd_data = mem[rbank][rd_addr].
  - rd_addr >= cnt[rbank]: rd_data=0, rd_valid=1, err set.
  - rd_en while buf_ready=0: ignored; rd_valid=0.
  - rd_valid is low in every cycle not following an accepted rd_en; rd_data holds its last value.
- compute_done with buf_ready=1: state[rbank]=EMPTY, rbank toggles; buf_ready reflects the new rbank the next cycle.
- compute_done with buf_ready=0: ignored; err set.
- Simultaneous events:
  - rd_en with compute_done in the same cycle: read is served from the old bank.
  - in_finish and compute_done in the same cycle on different banks: both take effect.
  - The fill bank and read bank are never the same non-EMPTY bank, because the bank states enforce exclusivity.
- err: sticky; cleared only by sys_rst.
- Reset mid-fill or mid-read: everything returns to reset values; partial data is discarded. The loader upstream is reset by the same reset.

Test Plan:
- Basic fill: fill_en=1 → layer_load_start pulse 1 cycle after reset release; 5 in_en words (0x1..0x5) then in_finish → buf_ready=1, rd_words=5; rd_addr=3 → rd_data=0x4 exactly 1 cycle later, rd_valid=1 for 1 cycle.
- Ping-pong overlap: while bank0 is FULL, a second layer_load_start fills bank1 with 8 words; compute_done → rd_words=8 next cycle; a third layer_load_start goes to bank0 the cycle after it frees.
- Backpressure: both banks FULL → no layer_load_start until compute_done; exactly one pulse after it.
- Overflow: 65 words in one layer → cnt=64, err=1, word 65 not stored (mem[63] holds word 64).
- Protocol errors: rd_en while buf_ready=0 → no rd_valid; rd_addr=10 with cnt=5 → rd_data=0, err=1; stray in_en in IDLE → err=1.
- Corner cases: in_finish with zero words → buf_ready=1, rd_words=0; in_en+in_finish in the same cycle → count includes that word; sys_rst mid-fill → all outputs 0, next layer_load_start pulse targets bank0.

Source files
------------

// File: rtl/weight_pingpong_buf.sv
// Ping-pong weight store between the flash loader and the compute engine:
// one bank fills from the loader while the other is exposed for reads.
module weight_pingpong_buf #(
  parameter int DATA_W = 256,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              fill_en,
  output logic              layer_load_start,
  input  logic              in_en,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_finish,
  output logic              buf_ready,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W:0]   rd_words,
  input  logic              compute_done,
  output logic              err
);

  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL} bank_st_t;
  typedef enum logic {F_IDLE, F_FILL} fill_st_t;

  logic [DATA_W-1:0] mem [2*DEPTH];
  bank_st_t          bank_st [2];
  logic [ADDR_W:0]   cnt [2];
  fill_st_t          fill_st;
  logic              wbank;
  logic              rbank;
  logic [ADDR_W:0]   waddr;

  logic              wr_ok;
  logic              wr_drop;
  logic              rd_acc;
  logic              rd_oob;
  logic [DATA_W-1:0] rd_data_p1;
  logic              vld_p1;

  // waddr's top bit marks a bank that already holds DEPTH words
  always_comb begin
    wr_ok   = (fill_st == F_FILL) && in_en && !waddr[ADDR_W];
    wr_drop = (fill_st == F_FILL) && in_en &&  waddr[ADDR_W];
    rd_acc  = rd_en && buf_ready;
    rd_oob  = {1'b0, rd_addr} >= cnt[rbank];
  end

  assign buf_ready = (bank_st[rbank] == B_FULL);
  assign rd_words  = buf_ready ? cnt[rbank] : '0;
  assign rd_data   = rd_data_p1;
  assign rd_valid  = vld_p1;

  always_ff @(posedge sys_clk) begin
    if (wr_ok)
      mem[{wbank, waddr[ADDR_W-1:0]}] <= in_data;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      fill_st          <= F_IDLE;
      bank_st[0]       <= B_EMPTY;
      bank_st[1]       <= B_EMPTY;
      cnt[0]           <= '0;
      cnt[1]           <= '0;
      wbank            <= 1'b0;
      rbank            <= 1'b0;
      waddr            <= '0;
      layer_load_start <= 1'b0;
      err              <= 1'b0;
    end else begin
      layer_load_start <= 1'b0;
      case (fill_st)
        F_IDLE: begin
          if (in_en || in_finish)
            err <= 1'b1;
          if (fill_en && (bank_st[wbank] == B_EMPTY)) begin
            layer_load_start <= 1'b1;
            bank_st[wbank]   <= B_FILLING;
            waddr            <= '0;
            fill_st          <= F_FILL;
          end
        end
        F_FILL: begin
          if (wr_ok)
            waddr <= waddr + (ADDR_W+1)'(1);
          if (wr_drop)
            err <= 1'b1;
          // a word written alongside the finish pulse still counts
          if (in_finish) begin
            cnt[wbank]     <= waddr + (ADDR_W+1)'(wr_ok);
            bank_st[wbank] <= B_FULL;
            wbank          <= ~wbank;
            fill_st        <= F_IDLE;
          end
        end
      endcase
      if (rd_acc && rd_oob)
        err <= 1'b1;
      // release touches only the FULL read bank, never the filling bank
      if (compute_done) begin
        if (buf_ready) begin
          bank_st[rbank] <= B_EMPTY;
          rbank          <= ~rbank;
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

  // read stage p1: registered data and its valid
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      vld_p1     <= 1'b0;
      rd_data_p1 <= '0;
    end else begin
      vld_p1 <= rd_acc;
      if (rd_acc)
        rd_data_p1 <= rd_oob ? '0 : mem[{rbank, rd_addr}];
    end
  end

endmodule
